match_scan_unit: RTL



---
 rtl/match_scan_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/match_scan_unit.sv
// Multi-cycle bit-granular pattern matcher for MATCH-family instructions.
// Scans LANES offsets per cycle; returns the first-match index, the last-match index or the match count.
module match_scan_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PAT_W  = 8,
  parameter int unsigned LANES  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              cancel,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       match_result
);

  localparam int unsigned NPOS    = DATA_W - PAT_W + 1;
  localparam int unsigned NCHUNK  = (NPOS + LANES - 1) / LANES;
  localparam int unsigned CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CNT_W   = $clog2(NPOS + 1);

  localparam logic [1:0] ModeLast  = 2'b01;
  localparam logic [1:0] ModeCount = 2'b10;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [DATA_W-1:0]   rt_q, rt_d;
  logic [1:0]          mode_q, mode_d;
  logic [CHUNK_W-1:0]  chunk_q, chunk_d;
  logic                found_q, found_d;
  logic [31:0]         best_q, best_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         result_q, result_d;

  logic [31:0]         base;
  logic [LANES-1:0]    hits;
  logic [31:0]         first_off;
  logic [31:0]         last_off;
  logic [CNT_W-1:0]    hit_cnt;
  logic                last_chunk;

  function automatic logic window_match(input logic [DATA_W-1:0] w,
                                        input logic [PAT_W-1:0]  pat,
                                        input logic [31:0]       p);
    logic [DATA_W-1:0] s;
    s = w >> p;
    return s[PAT_W-1:0] == pat;
  endfunction

  // Per-chunk lane compare; lanes past the last valid offset are masked.
  always_comb begin
    base      = 32'(chunk_q) * 32'(LANES);
    hits      = '0;
    hit_cnt   = '0;
    first_off = '0;
    last_off  = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (base + 32'(l) < 32'(NPOS)) begin
        hits[l] = window_match(rt_q, pat_q, base + 32'(l));
      end
    end
    for (int l = 0; l < int'(LANES); l++) begin
      if (hits[l]) begin
        last_off = base + 32'(l);
        hit_cnt  = hit_cnt + CNT_W'(1);
      end
    end
    for (int l = int'(LANES) - 1; l >= 0; l--) begin
      if (hits[l]) first_off = base + 32'(l);
    end
    last_chunk = (32'(chunk_q) == 32'(NCHUNK - 1));
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    rt_d     = rt_q;
    mode_d   = mode_q;
    chunk_d  = chunk_q;
    found_d  = found_q;
    best_d   = best_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !cancel) begin
          pat_d   = rs_data[PAT_W-1:0];
          rt_d    = rt_data;
          mode_d  = req_mode;
          chunk_d = '0;
          found_d = 1'b0;
          best_d  = '0;
          cnt_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        chunk_d = chunk_q + CHUNK_W'(1);
        case (mode_q)
          ModeLast: begin
            if (|hits) begin
              found_d = 1'b1;
              best_d  = last_off;
            end
            if (last_chunk) begin
              result_d = found_d ? best_d : '1;
              state_d  = StDone;
            end
          end
          ModeCount: begin
            cnt_d = cnt_q + hit_cnt;
            if (last_chunk) begin
              result_d = 32'(cnt_d);
              state_d  = StDone;
            end
          end
          default: begin
            // FIRST (and mode 11) exits on the earliest hit.
            if (|hits) begin
              result_d = first_off;
              state_d  = StDone;
            end else if (last_chunk) begin
              result_d = '1;
              state_d  = StDone;
            end
          end
        endcase
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (cancel) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      rt_q     <= '0;
      mode_q   <= '0;
      chunk_q  <= '0;
      found_q  <= 1'b0;
      best_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      rt_q     <= rt_d;
      mode_q   <= mode_d;
      chunk_q  <= chunk_d;
      found_q  <= found_d;
      best_q   <= best_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign resp_valid   = (state_q == StDone);
  assign match_result = result_q;

endmodule
